// File: rtl/uart_pkg.sv
// Shared definitions for the UART loopback path: byte width and the
// receive-buffer controller state encoding.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO between the UART Receiver and the TX handoff FSM.
// A write into a full FIFO is still accepted when a read happens on the same
// edge. The read port is combinational, so a same-edge write to the slot
// being read leaves the old byte on rd_data.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic [PTR_W:0]    count,
  output logic              overflow
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              wr_ok;

  assign full    = (count == FULL_CNT);
  assign wr_ok   = wr_en && (!full || rd_en);
  assign rd_data = mem[rd_ptr];

  // Byte storage; contents are data only and carry no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !wr_ok) overflow <= 1'b1;
      case ({wr_ok, rd_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffer_ctrl.sv
// Loopback buffer: captures Receiver bytes into a FIFO and hands them one at
// a time to the Sender with a one-cycle TX_EN pulse. If the Sender does not
// go busy within BUSY_TIMEOUT cycles of the pulse, TX_EN is re-issued with
// the same TX_DATA.
module uart_rx_buffer_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int PTR_W        = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic              BaudRate_clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] RX_DATA,
  input  logic              RX_STATUS,
  input  logic              TX_STATUS,
  output logic [BYTE_W-1:0] TX_DATA,
  output logic              TX_EN,
  output logic [PTR_W:0]    FIFO_COUNT,
  output logic              OVERFLOW
);

  localparam int              TMR_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  uart_state_e       state;
  uart_state_e       state_nx;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  timer_nx;
  logic              rd_en;
  logic [BYTE_W-1:0] fifo_rd_data;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (BaudRate_clk),
    .rst_n    (reset),
    .wr_en    (RX_STATUS),
    .wr_data  (RX_DATA),
    .rd_en    (rd_en),
    .rd_data  (fifo_rd_data),
    .count    (FIFO_COUNT),
    .overflow (OVERFLOW)
  );

  // Handoff FSM: next state, FIFO read strobe and busy-wait timer.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    rd_en    = 1'b0;
    unique case (state)
      IDLE: begin
        if ((FIFO_COUNT != '0) && TX_STATUS) state_nx = LOAD;
      end
      LOAD: begin
        rd_en    = 1'b1;
        state_nx = START;
      end
      START: begin
        timer_nx = '0;
        state_nx = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!TX_STATUS)             state_nx = WAIT_DONE;
        else if (timer == TMR_LAST) state_nx = START;
        else                        timer_nx = timer + TMR_W'(1);
      end
      WAIT_DONE: begin
        if (TX_STATUS) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, timer and registered TX outputs; TX_EN is high exactly while in START.
  always_ff @(posedge BaudRate_clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      timer   <= '0;
      TX_EN   <= 1'b0;
      TX_DATA <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      TX_EN <= (state_nx == START);
      if (rd_en) TX_DATA <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// Directed bench for uart_rx_buffer_ctrl with a simple Sender model.
module tb_uart_rx_buffer_ctrl;

  localparam int FRAME = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       tx_status;
  logic [7:0] tx_data;
  logic       tx_en;
  logic [3:0] fifo_count;
  logic       overflow;

  // Sender model state
  logic       hold = 1'b0;
  int         busy_cnt = 0;
  int         ign_req = 0;
  int         ign_done = 0;
  int         accepted = 0;
  logic [7:0] en_q[$];
  logic       prev_en = 1'b0;
  logic       consec = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign tx_status = ~hold & (busy_cnt == 0);

  uart_rx_buffer_ctrl dut (
    .BaudRate_clk (clk),
    .reset        (reset),
    .RX_DATA      (rx_data),
    .RX_STATUS    (rx_status),
    .TX_STATUS    (tx_status),
    .TX_DATA      (tx_data),
    .TX_EN        (tx_en),
    .FIFO_COUNT   (fifo_count),
    .OVERFLOW     (overflow)
  );

  // Sender: logs every TX_EN, goes busy for FRAME cycles unless told to ignore it.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
      prev_en  = 1'b0;
    end else begin
      if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      if (tx_en) begin
        en_q.push_back(tx_data);
        if (prev_en) consec = 1'b1;
        if (ign_req != ign_done) ign_done = ign_done + 1;
        else if (!hold) begin
          busy_cnt = FRAME;
          accepted = accepted + 1;
        end
      end
      prev_en = tx_en;
    end
  end

  task automatic rx_pulse(input logic [7:0] d);
    rx_data   = d;
    rx_status = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_status = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_status = 1'b0;
    #3 reset  = 1'b0;
    #1;
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en got %b want 0", tx_en); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int base = en_q.size();
    int acc0 = accepted;
    rx_pulse(8'hA5);
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_cnt_e0 got %0d want 1", fifo_count); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_en_e1 got %b want 0", tx_en); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL single_en_e2 got %b want 1", tx_en); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", tx_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_cnt_e2 got %0d want 0", fifo_count); end
    @(negedge clk);
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL single_en_e3 got %b want 0", tx_en); end
    repeat (200) @(negedge clk);
    checks++; if (en_q.size() - base !== 1) begin errors++; $display("FAIL single_pulses got %0d want 1", en_q.size() - base); end
    checks++; if (accepted - acc0 !== 1) begin errors++; $display("FAIL single_frames got %0d want 1", accepted - acc0); end
  endtask

  task automatic test_burst();
    int base = en_q.size();
    logic [7:0] want;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_pulse(8'h01 + 8'(i));
      repeat (3) @(negedge clk);
    end
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL burst_peak got %0d want 3", fifo_count); end
    hold = 1'b0;
    repeat (600) @(negedge clk);
    checks++;
    if (en_q.size() - base !== 3) begin
      errors++; $display("FAIL burst_pulses got %0d want 3", en_q.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        want = 8'h01 + 8'(i);
        checks++; if (en_q[base+i] !== want) begin errors++; $display("FAIL burst_order[%0d] got %h want %h", i, en_q[base+i], want); end
      end
    end
  endtask

  task automatic test_overflow();
    int base = en_q.size();
    logic [7:0] want;
    hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rx_pulse(8'h10 + 8'(i));
      if (i == 7) begin
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_full_cnt got %0d want 8", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", overflow); end
      end
      @(negedge clk);
    end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_sat_cnt got %0d want 8", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    hold = 1'b0;
    repeat (1600) @(negedge clk);
    checks++;
    if (en_q.size() - base !== 8) begin
      errors++; $display("FAIL ovf_pulses got %0d want 8", en_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        want = 8'h10 + 8'(i);
        checks++; if (en_q[base+i] !== want) begin errors++; $display("FAIL ovf_order[%0d] got %h want %h", i, en_q[base+i], want); end
      end
    end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL ovf_drained got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_timeout();
    int base = en_q.size();
    int acc0 = accepted;
    logic [7:0] pat = 8'b0100_0010;
    ign_req = ign_req + 1;
    rx_pulse(8'hB7);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if (tx_en !== pat[i-1]) begin errors++; $display("FAIL tmo_en_e%0d got %b want %b", i, tx_en, pat[i-1]); end
      if (i == 7) begin
        checks++; if (tx_data !== 8'hB7) begin errors++; $display("FAIL tmo_data got %h want b7", tx_data); end
      end
    end
    repeat (200) @(negedge clk);
    checks++; if (en_q.size() - base !== 2) begin errors++; $display("FAIL tmo_pulses got %0d want 2", en_q.size() - base); end
    checks++; if (accepted - acc0 !== 1) begin errors++; $display("FAIL tmo_frames got %0d want 1", accepted - acc0); end
  endtask

  task automatic test_full_rw();
    apply_reset();
    hold = 1'b1;
    for (int i = 0; i < 8; i++) rx_pulse(8'h20 + 8'(i));
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL frw_fill got %0d want 8", fifo_count); end
    hold = 1'b0;
    @(negedge clk);
    rx_pulse(8'h28);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL frw_cnt got %0d want 8", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf got %b want 0", overflow); end
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL frw_en got %b want 1", tx_en); end
    checks++; if (tx_data !== 8'h20) begin errors++; $display("FAIL frw_data got %h want 20", tx_data); end
  endtask

  task automatic test_reset_mid();
    int base;
    int n = 0;
    while (fifo_count !== 4'd5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (fifo_count !== 4'd5) begin errors++; $display("FAIL mid_reach5 got %0d want 5", fifo_count); end
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_tx_data got %h want 00", tx_data); end
    checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL mid_tx_en got %b want 0", tx_en); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b want 0", overflow); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    base = en_q.size();
    repeat (50) @(negedge clk);
    checks++; if (en_q.size() - base !== 0) begin errors++; $display("FAIL mid_quiet got %0d want 0", en_q.size() - base); end
    rx_pulse(8'h3C);
    repeat (2) @(negedge clk);
    checks++; if (tx_en !== 1'b1) begin errors++; $display("FAIL mid_new_en got %b want 1", tx_en); end
    checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL mid_new_data got %h want 3c", tx_data); end
    repeat (200) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_full_rw();
    test_reset_mid();
    checks++; if (consec !== 1'b0) begin errors++; $display("FAIL en_consecutive got %b want 0", consec); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer_ctrl.md
Name: uart_rx_buffer_ctrl

Overview:
Downstream consumer of the UART Receiver: captures each byte presented on RX_DATA/RX_STATUS into a small circular FIFO. Drains the FIFO into the UART Sender using a one-cycle TX_EN start pulse and the Sender's TX_STATUS ready flag, forming the loopback/echo path. Runs entirely in the BaudRate_clk domain shared with Receiver and Sender.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
PTR_W, 3, pointer width = log2(DEPTH).
BUSY_TIMEOUT, 4, cycles to wait for TX_STATUS to fall after TX_EN before re-issuing TX_EN.

Ports:
BaudRate_clk  input  1  sole clock, rising edge.
reset  input  1  asynchronous, active-low (0 = reset asserted).
RX_DATA  input  8  byte from Receiver; valid only in cycles where RX_STATUS=1.
RX_STATUS  input  1  one-cycle pulse from Receiver: RX_DATA valid.
TX_STATUS  input  1  Sender ready: 1 = idle, 0 = transmitting.
TX_DATA  output  8  byte to Sender; held stable from LOAD until the next LOAD.
TX_EN  output  1  one-cycle start pulse to Sender.
FIFO_COUNT  output  PTR_W+1  current occupancy, 0..DEPTH.
OVERFLOW  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous): TX_DATA=8'h00, TX_EN=0, FIFO_COUNT=0, OVERFLOW=0, wr_ptr=rd_ptr=0, state=IDLE.
  - Applies immediately, mid-operation included; any in-flight handoff is abandoned and FIFO contents are discarded.
- Write: on a rising edge with RX_STATUS=1 and (count<DEPTH or a read occurs on the same edge):
  - mem[wr_ptr]<=RX_DATA; wr_ptr increments modulo DEPTH (natural wrap).
- Full drop: RX_STATUS=1, count==DEPTH and no read on that edge -> byte discarded, pointers unchanged, OVERFLOW<=1.
  - OVERFLOW clears only on reset.
- Read: occurs only on the edge that leaves state LOAD.
  - TX_DATA<=mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- Count update:
  - Write only: +1.
  - Read only: -1.
  - Write and read on the same edge: unchanged.
  - FIFO_COUNT reflects the new value one cycle after the edge.
- Read-before-write: on a simultaneous read and write at the same address (count==0 is impossible in LOAD), the read returns the old entry.
- FSM, one transition per clock edge:
  - IDLE: if count>0 and TX_STATUS=1 -> LOAD; else stay.
  - LOAD: perform the read -> START.
  - START: TX_EN=1 for exactly this cycle; clear timer -> WAIT_BUSY.
  - WAIT_BUSY: if TX_STATUS=0 -> WAIT_DONE.
    - Else if timer reaches BUSY_TIMEOUT-1 -> START (re-pulse TX_EN, same TX_DATA).
    - Else increment timer.
  - WAIT_DONE: if TX_STATUS=1 -> IDLE.
- TX_EN is a registered output; it is high only in START, so it is never high two consecutive cycles.
- Minimum byte-to-TX_EN latency, empty FIFO and idle Sender:
  - RX_STATUS pulse sampled at edge E0.
  - count=1 after E0; IDLE->LOAD at E1; LOAD->START at E2.
  - TX_EN high E2..E3.
- Back-to-back bytes: the next LOAD requires a return to IDLE with TX_STATUS=1; there is no pipelining across Sender frames.
- Writes continue in every FSM state; the FIFO never blocks the Receiver except through a full drop.

Decomposition:
- Shared package (uart_pkg): FSM state encoding (IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, 3 bits), byte width constant 8.
- One natural sub-module: uart_byte_fifo.
  - Holds memory, pointers, count, overflow.
  - Interface: wr_en/wr_data, rd_en/rd_data, count, overflow.
- Controller FSM and TX outputs stay in the top module.

Test Plan:
1. Reset released, single RX_STATUS pulse with RX_DATA=8'hA5, TX_STATUS=1 held, and a Sender model that drops TX_STATUS 1 cycle after TX_EN for 160 cycles.
   - TX_EN pulses exactly once, 2 edges after the write, with TX_DATA=8'hA5.
   - FIFO_COUNT goes 0->1->0.
2. Burst of 3 pulses (8'h01, 8'h02, 8'h03) spaced 4 cycles apart while the Sender is busy.
   - FIFO_COUNT peaks at 3.
   - TX_DATA is transmitted in order 01, 02, 03, one TX_EN per Sender frame.
3. TX_STATUS held 0; 9 pulses with bytes 8'h10..8'h18.
   - FIFO_COUNT saturates at 8 and OVERFLOW=1.
   - After TX_STATUS is released, the output order is 10..17; 18 is never sent.
4. Sender model ignores the first TX_EN (TX_STATUS stays 1).
   - TX_EN re-pulses after BUSY_TIMEOUT=4 cycles with unchanged TX_DATA.
   - The byte is sent exactly once after the Sender responds.
5. FIFO full (8 entries), with an RX_STATUS pulse on the exact edge leaving LOAD.
   - The byte is accepted, FIFO_COUNT stays 8, OVERFLOW stays 0.
6. reset driven 0 while in WAIT_DONE with count=5.
   - All outputs take reset values immediately, before the next clock edge.
   - After release, no TX_EN until a new RX_STATUS pulse arrives.
